// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column strobing, 2-FF row synchroniser, frame-based debounce,
// single-key arbitration and a valid/ack key output with a sticky overrun flag.
module keypad_scanner #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 12000,
  parameter int DEBOUNCE = 4,
  localparam int KW      = $clog2(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ROWS-1:0] rows,
  output logic [COLS-1:0] columns,
  output logic [KW-1:0]   key,
  output logic            key_valid,
  input  logic            key_ack,
  output logic            key_held,
  output logic            overrun
);

  localparam int NK  = ROWS * COLS;
  localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CIW = $clog2(COLS);
  localparam int CW  = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {S_IDLE, S_DEB, S_HELD} state_t;

  logic [ROWS-1:0] rows_s1_q, rows_s2_q;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [CIW-1:0]  col_q, col_d;
  logic [NK-1:0]   map_q, map_d;
  state_t          state_q, state_d;
  logic [KW-1:0]   cand_q, cand_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [KW-1:0]   key_q, key_d;
  logic            key_valid_q, key_valid_d;
  logic            overrun_q, overrun_d;

  logic            sample, frame_end, accept, single, held_present;
  logic [1:0]      n_hit;
  logic [KW-1:0]   low_code;

  assign sample    = (dwell_q == DW'(SCAN_DIV - 1));
  assign frame_end = sample && (col_q == CIW'(COLS - 1));
  assign cnt_inc   = cnt_q + CW'(1);

  always_comb begin
    dwell_d = sample ? '0 : dwell_q + DW'(1);
    col_d   = col_q;
    if (sample) col_d = (col_q == CIW'(COLS - 1)) ? '0 : col_q + CIW'(1);
  end

  // map_d already holds the column being sampled, so the frame result is complete at frame end
  always_comb begin
    map_d = map_q;
    if (sample) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (CIW'(c) == col_q) map_d[r*COLS + c] = rows_s2_q[r];
        end
      end
    end
  end

  always_comb begin
    n_hit    = 2'd0;
    low_code = '0;
    for (int i = NK - 1; i >= 0; i--) begin
      if (map_d[i]) begin
        low_code = KW'(i);
        if (n_hit != 2'd2) n_hit = n_hit + 2'd1;
      end
    end
  end

  assign single       = (n_hit == 2'd1);
  assign held_present = map_d[cand_q];

  // cnt_q is the press count in S_DEB and the release count in S_HELD
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (frame_end) begin
      case (state_q)
        S_IDLE: begin
          if (single) begin
            cand_d = low_code;
            if (DEBOUNCE == 1) begin
              accept  = 1'b1;
              state_d = S_HELD;
              cnt_d   = '0;
            end else begin
              state_d = S_DEB;
              cnt_d   = CW'(1);
            end
          end
        end
        S_DEB: begin
          if (single && (low_code == cand_q)) begin
            if (cnt_inc == CW'(DEBOUNCE)) begin
              accept  = 1'b1;
              state_d = S_HELD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        S_HELD: begin
          if (held_present) begin
            cnt_d = '0;
          end else if (cnt_inc == CW'(DEBOUNCE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // An accept coinciding with ack replaces the consumed key instead of flagging overrun
  always_comb begin
    key_d       = key_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    if (accept) begin
      if (!key_valid_q || key_ack) begin
        key_d       = cand_d;
        key_valid_d = 1'b1;
        if (key_ack) overrun_d = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (key_ack && key_valid_q) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_s1_q   <= '0;
      rows_s2_q   <= '0;
      dwell_q     <= '0;
      col_q       <= '0;
      map_q       <= '0;
      state_q     <= S_IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rows_s1_q   <= rows;
      rows_s2_q   <= rows_s1_q;
      dwell_q     <= dwell_d;
      col_q       <= col_d;
      map_q       <= map_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign columns   = {{(COLS-1){1'b0}}, 1'b1} << col_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == S_HELD);
  assign overrun   = overrun_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner with debounce, single-key arbitration and a held-until-acknowledged key output. It drives one-hot column strobes, samples synchronised row inputs, and debounces each accepted key over whole scan frames. It reports a binary key code to the Nios/bus side through a valid/ack handshake with overrun flagging. It is the sequential successor to the combinational keypad decoder and sits between the keypad pins and the processor interface.

## Interface
- ROWS, 4, number of row inputs (>=1)
- COLS, 4, number of column strobes (>=2)
- SCAN_DIV, 12000, clk cycles each column is driven (dwell); must be >=4
- DEBOUNCE, 4, consecutive matching frames needed to accept a press or a release (>=1)
- KW (localparam), clog2(ROWS*COLS), key code width
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rows  in  ROWS  row sense lines, active-high; a pressed key at (r,c) drives rows[r] high while columns[c] is high
- columns  out  COLS  one-hot active-high column strobe
- key  out  KW  accepted key code = r*COLS + c
- key_valid  out  1  key holds an unconsumed code
- key_ack  in  1  consumer acknowledge; consumes key when sampled with key_valid=1
- key_held  out  1  accepted key is still physically down
- overrun  out  1  sticky: a new key was accepted while key_valid was still set

## Operation
- rows passes through a 2-FF synchroniser before any use.
- Scan: a dwell counter counts 0..SCAN_DIV-1 per column. Column index advances on wrap and wraps COLS-1 -> 0. Synchronised rows are sampled on the last dwell cycle, count SCAN_DIV-1, into a per-frame press map.
- Frame end is the sample of column COLS-1. The frame result is: count of pressed keys (0, 1, >1), code of the lowest-index pressed key, and whether the currently held code is present.
- FSM, evaluated once per frame end:
  - IDLE: exactly one key pressed -> DEBOUNCE, cand=code, cnt=1, then cnt==DEBOUNCE check applies. Zero or multiple keys -> stay.
  - DEBOUNCE: the same single key -> cnt+1. Any other result -> IDLE. Reaching cnt==DEBOUNCE -> accept cand, go HELD. With DEBOUNCE=1, acceptance occurs on the first frame.
  - HELD: key_held=1. If the held code is present in the frame, rcnt=0; extra keys are ignored, with no ghost or rollover events. If it is absent, rcnt+1. At rcnt==DEBOUNCE -> IDLE, key_held=0.
- Accept with key_valid=0: key<=cand, key_valid<=1.
- Accept with key_valid=1 and no key_ack that cycle: key unchanged, new code dropped, overrun<=1.
- Accept in the same cycle as key_ack: the old key is consumed, the new key is loaded, key_valid stays 1, no overrun.
- key_ack with key_valid=1 and no accept: key_valid<=0, overrun<=0. key_ack with key_valid=0 is ignored.
- key is stable whenever key_valid=1.

## Timing
- Reset (async assert, release synchronous to clk): columns=1 (column 0), dwell=0, FSM=IDLE, key=0, key_valid=0, key_held=0, overrun=0, synchroniser and counters cleared.
- Reset mid-scan or mid-debounce aborts everything, with no partial event.
- columns changes on the cycle after dwell count SCAN_DIV-1; frame = COLS*SCAN_DIV cycles.
- Row input to sample: 2 cycles of synchroniser latency, so a row change must precede the sample cycle by >=2 cycles.
- FSM state, key, key_valid and key_held update 1 cycle after the frame-end sample.
- Press latency: DEBOUNCE frames of steady press, plus up to one partial frame, plus 1 cycle.
- key_valid falls 1 cycle after the ack edge.

## Test plan
Parameters for all scenarios: ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3 (frame = 16 cycles).
- Reset, rows=0 -> columns=0001 with all outputs 0; columns=0010 after 4 cycles; back to 0001 after 16 cycles.
- Key (r1,c2) held steady -> key=6, key_valid=1 and key_held=1 one cycle after the 3rd matching frame end; key_ack pulse -> key_valid=0 next cycle with key still 6; release -> key_held=0 after 3 empty frames.
- Key (r1,c2) pressed for 1 frame then released (bounce) -> no key_valid; FSM returns to IDLE.
- Keys 5 and 9 pressed together from IDLE -> no accept. Hold 5 until accepted, then add 9 -> no new event. Release 5 while 9 stays down -> key_held drops after 3 frames, then key=9 is accepted (overrun=1 if 5 was not acked).
- Accept 6 with no ack, release, press 3 -> overrun=1 with key still 6; key_ack -> key_valid=0 and overrun=0. Repeat with key_ack asserted on the exact accept cycle of 3 -> key=3, key_valid=1, overrun=0.
- rst_n asserted mid-DEBOUNCE and mid-HELD -> all outputs 0 and columns=0001 immediately; a steady key is re-accepted after 3 frames.
